// File: rtl/multi_dataflow_job_dispatcher.sv
// Job descriptor queue and sequencer for multi_dataflow_fsm: buffers jobs,
// issues them one at a time, and reports completion or watchdog timeout.
module multi_dataflow_job_dispatcher #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ID_W        = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [ID_W-1:0]              push_id_i,
  input  logic [CNT_W-1:0]             push_limit_i,
  input  logic [CNT_W-1:0]             wd_limit_i,
  output logic                         fsm_start_o,
  input  logic                         fsm_done_i,
  output logic                         fsm_abort_o,
  output logic [CNT_W-1:0]             cnt_limit_o,
  output logic [ID_W-1:0]              job_id_o,
  output logic                         evt_o,
  output logic [ID_W-1:0]              evt_id_o,
  output logic                         evt_err_o,
  output logic [$clog2(QUEUE_DEPTH):0] level_o,
  output logic                         busy_o,
  output logic                         timeout_o,
  output logic [CNT_W-1:0]             jobs_done_o
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] limit;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_ABORT,
    ST_REPORT
  } state_e;

  state_e           state_q;
  desc_t            mem_q [QUEUE_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] cnt_limit_q, jobs_done_q;
  logic [ID_W-1:0]  job_id_q, evt_id_q;
  logic             fsm_start_q, fsm_abort_q, evt_q, evt_err_q, timeout_q;

  logic             push_fire;
  logic             pop;
  logic             wd_hit;
  desc_t            head;

  assign push_ready_o = (level_q < LW'(QUEUE_DEPTH));
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop          = (state_q == ST_REPORT);
  assign head         = mem_q[rd_q];
  assign wd_hit       = (wd_limit_i != '0) && (wd_cnt_q == (wd_limit_i - CNT_W'(1)));

  // Occupancy counts the running job too; the head is only released in REPORT.
  always_comb begin
    level_d = level_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_fire) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push_fire, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_fire && !clear_i) begin
      mem_q[wr_q] <= desc_t'{id: push_id_i, limit: push_limit_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Sequencer: pulse outputs default low every cycle and are set on entry to their state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wd_cnt_q    <= '0;
      cnt_limit_q <= '0;
      job_id_q    <= '0;
      evt_id_q    <= '0;
      evt_err_q   <= 1'b0;
      jobs_done_q <= '0;
      fsm_start_q <= 1'b0;
      fsm_abort_q <= 1'b0;
      evt_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (clear_i) begin
      state_q     <= ST_IDLE;
      wd_cnt_q    <= '0;
      cnt_limit_q <= '0;
      job_id_q    <= '0;
      evt_id_q    <= '0;
      evt_err_q   <= 1'b0;
      jobs_done_q <= '0;
      fsm_start_q <= 1'b0;
      fsm_abort_q <= 1'b0;
      evt_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      fsm_start_q <= 1'b0;
      fsm_abort_q <= 1'b0;
      evt_q       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (level_q != '0) begin
            job_id_q    <= head.id;
            cnt_limit_q <= head.limit;
            fsm_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt_q <= '0;
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          wd_cnt_q <= wd_cnt_q + CNT_W'(1);
          // Done takes priority over a watchdog expiry in the same cycle.
          if (fsm_done_i) begin
            evt_q     <= 1'b1;
            evt_id_q  <= job_id_q;
            evt_err_q <= 1'b0;
            state_q   <= ST_REPORT;
          end else if (wd_hit) begin
            fsm_abort_q <= 1'b1;
            timeout_q   <= 1'b1;
            state_q     <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          evt_q     <= 1'b1;
          evt_id_q  <= job_id_q;
          evt_err_q <= 1'b1;
          state_q   <= ST_REPORT;
        end
        ST_REPORT: begin
          jobs_done_q <= jobs_done_q + CNT_W'(1);
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE) || (level_q != '0);
  assign level_o     = level_q;
  assign fsm_start_o = fsm_start_q;
  assign fsm_abort_o = fsm_abort_q;
  assign cnt_limit_o = cnt_limit_q;
  assign job_id_o    = job_id_q;
  assign evt_o       = evt_q;
  assign evt_id_o    = evt_id_q;
  assign evt_err_o   = evt_err_q;
  assign timeout_o   = timeout_q;
  assign jobs_done_o = jobs_done_q;

endmodule

// File: tb/tb_multi_dataflow_job_dispatcher.sv
// Scoreboard bench for multi_dataflow_job_dispatcher: directed jobs push expected
// starts/events into queues; a negedge monitor pops and compares them.
module tb_multi_dataflow_job_dispatcher;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        push_valid_i = 1'b0;
  logic        push_ready_o;
  logic [7:0]  push_id_i = '0;
  logic [15:0] push_limit_i = '0;
  logic [15:0] wd_limit_i = '0;
  logic        fsm_start_o;
  logic        fsm_done_i = 1'b0;
  logic        fsm_abort_o;
  logic [15:0] cnt_limit_o;
  logic [7:0]  job_id_o;
  logic        evt_o;
  logic [7:0]  evt_id_o;
  logic        evt_err_o;
  logic [2:0]  level_o;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] jobs_done_o;

  multi_dataflow_job_dispatcher #(
    .QUEUE_DEPTH(4), .ID_W(8), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_id_i(push_id_i), .push_limit_i(push_limit_i), .wd_limit_i(wd_limit_i),
    .fsm_start_o(fsm_start_o), .fsm_done_i(fsm_done_i), .fsm_abort_o(fsm_abort_o),
    .cnt_limit_o(cnt_limit_o), .job_id_o(job_id_o),
    .evt_o(evt_o), .evt_id_o(evt_id_o), .evt_err_o(evt_err_o),
    .level_o(level_o), .busy_o(busy_o), .timeout_o(timeout_o), .jobs_done_o(jobs_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] id; logic [15:0] lim; } start_t;
  typedef struct { logic [7:0] id; logic err; } evt_t;

  start_t exp_start[$];
  evt_t   exp_evt[$];
  int     checks = 0;
  int     errors = 0;
  int     abort_cnt = 0;
  int     npulse;
  bit     mon_en = 1'b0;
  start_t s_pop;
  evt_t   e_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_job(input logic [7:0] id, input logic [15:0] lim, input logic err);
    int guard = 0;
    push_valid_i = 1'b1;
    push_id_i    = id;
    push_limit_i = lim;
    while (!push_ready_o && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: id 0x%0h never accepted", id);
    end
    exp_start.push_back('{id: id, lim: lim});
    exp_evt.push_back('{id: id, err: err});
    step();
    push_valid_i = 1'b0;
  endtask

  // Done pulse d cycles after the current (start) cycle; returns on the event cycle.
  task automatic finish_job(input int d);
    repeat (d) step();
    fsm_done_i = 1'b1;
    step();
    fsm_done_i = 1'b0;
    chk("evt_after_done", 32'(evt_o), 32'd1);
  endtask

  // Monitor: compares every start and event against the scoreboard.
  always @(negedge clk_i) begin
    if (mon_en) begin
      npulse = int'(fsm_start_o) + int'(fsm_abort_o) + int'(evt_o);
      if (npulse > 0) chk("pulse_overlap", 32'(npulse), 32'd1);
      if (fsm_abort_o) abort_cnt++;
      if (fsm_start_o) begin
        if (exp_start.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: got id 0x%0h expected none", job_id_o);
        end else begin
          s_pop = exp_start.pop_front();
          chk("start_id", 32'(job_id_o), 32'(s_pop.id));
          chk("start_limit", 32'(cnt_limit_o), 32'(s_pop.lim));
        end
      end
      if (evt_o) begin
        if (exp_evt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL evt_unexpected: got id 0x%0h expected none", evt_id_o);
        end else begin
          e_pop = exp_evt.pop_front();
          chk("evt_id", 32'(evt_id_o), 32'(e_pop.id));
          chk("evt_err", 32'(evt_err_o), 32'(e_pop.err));
        end
      end
    end
  end

  initial begin
    int aborts_before;
    repeat (2) step();
    rst_ni = 1'b1;
    mon_en = 1'b1;
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ready", 32'(push_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_jobs_done", 32'(jobs_done_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_job_id", 32'(job_id_o), 32'd0);
    chk("rst_cnt_limit", 32'(cnt_limit_o), 32'd0);
    chk("rst_evt_id", 32'(evt_id_o), 32'd0);

    // Single job
    push_job(8'h11, 16'd64, 1'b0);
    chk("t1_level", 32'(level_o), 32'd1);
    chk("t1_no_start_yet", 32'(fsm_start_o), 32'd0);
    step();
    chk("t1_start_cycle2", 32'(fsm_start_o), 32'd1);
    chk("t1_cnt_limit", 32'(cnt_limit_o), 32'd64);
    finish_job(10);
    step();
    chk("t1_jobs_done", 32'(jobs_done_o), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd0);

    // Full queue: five pushes, depth four
    push_job(8'h21, 16'd100, 1'b0);
    push_job(8'h22, 16'd101, 1'b0);
    push_job(8'h23, 16'd102, 1'b0);
    push_job(8'h24, 16'd103, 1'b0);
    chk("t2_level_full", 32'(level_o), 32'd4);
    chk("t2_ready_full", 32'(push_ready_o), 32'd0);
    push_valid_i = 1'b1;
    push_id_i    = 8'h25;
    push_limit_i = 16'd104;
    exp_start.push_back('{id: 8'h25, lim: 16'd104});
    exp_evt.push_back('{id: 8'h25, err: 1'b0});
    repeat (3) step();
    chk("t2_held_level", 32'(level_o), 32'd4);
    chk("t2_held_ready", 32'(push_ready_o), 32'd0);
    fsm_done_i = 1'b1;
    step();
    fsm_done_i = 1'b0;
    chk("t2_evt", 32'(evt_o), 32'd1);
    chk("t2_ready_in_report", 32'(push_ready_o), 32'd0);
    step();
    chk("t2_level_after_pop", 32'(level_o), 32'd3);
    chk("t2_ready_after_pop", 32'(push_ready_o), 32'd1);
    step();
    push_valid_i = 1'b0;
    chk("t2_level_refill", 32'(level_o), 32'd4);
    chk("t2_restart", 32'(fsm_start_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      finish_job(1);
      repeat (2) step();
      if (i < 3) chk("t2_start_spacing", 32'(fsm_start_o), 32'd1);
    end
    chk("t2_busy_end", 32'(busy_o), 32'd0);
    chk("t2_level_end", 32'(level_o), 32'd0);
    chk("t2_jobs_done", 32'(jobs_done_o), 32'd6);

    // Watchdog = 8: same-cycle done first, then a true timeout
    wd_limit_i = 16'd8;
    push_job(8'h32, 16'd201, 1'b0);
    push_job(8'h31, 16'd200, 1'b1);
    chk("t3_start_g", 32'(fsm_start_o), 32'd1);
    finish_job(8);
    chk("t3_tie_no_abort", 32'(fsm_abort_o), 32'd0);
    chk("t3_tie_timeout", 32'(timeout_o), 32'd0);
    repeat (2) step();
    chk("t3_start_f", 32'(fsm_start_o), 32'd1);
    repeat (8) step();
    chk("t3_no_abort_early", 32'(fsm_abort_o), 32'd0);
    chk("t3_timeout_early", 32'(timeout_o), 32'd0);
    step();
    chk("t3_abort", 32'(fsm_abort_o), 32'd1);
    chk("t3_timeout_set", 32'(timeout_o), 32'd1);
    step();
    chk("t3_evt_after_abort", 32'(evt_o), 32'd1);
    step();
    push_job(8'h33, 16'd300, 1'b0);
    step();
    chk("t3_next_start", 32'(fsm_start_o), 32'd1);
    finish_job(3);
    step();
    chk("t3_timeout_sticky", 32'(timeout_o), 32'd1);
    chk("t3_jobs_done", 32'(jobs_done_o), 32'd9);

    // Mid-run clear with three jobs queued
    wd_limit_i = 16'd0;
    push_job(8'h51, 16'd10, 1'b0);
    push_job(8'h52, 16'd11, 1'b0);
    push_job(8'h53, 16'd12, 1'b0);
    step();
    clear_i = 1'b1;
    exp_start.delete();
    exp_evt.delete();
    step();
    clear_i = 1'b0;
    chk("t5_level", 32'(level_o), 32'd0);
    chk("t5_evt", 32'(evt_o), 32'd0);
    chk("t5_jobs_done", 32'(jobs_done_o), 32'd0);
    chk("t5_ready", 32'(push_ready_o), 32'd1);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_timeout", 32'(timeout_o), 32'd0);
    chk("t5_job_id", 32'(job_id_o), 32'd0);
    repeat (3) step();
    chk("t5_no_restart", 32'(fsm_start_o), 32'd0);

    // Spurious done in IDLE and ISSUE; watchdog disabled for a long run
    fsm_done_i = 1'b1;
    step();
    fsm_done_i = 1'b0;
    chk("t4_idle_done_evt", 32'(evt_o), 32'd0);
    chk("t4_idle_done_busy", 32'(busy_o), 32'd0);
    push_job(8'h41, 16'd400, 1'b0);
    step();
    chk("t4_start", 32'(fsm_start_o), 32'd1);
    fsm_done_i = 1'b1;
    step();
    fsm_done_i = 1'b0;
    chk("t4_issue_done_evt", 32'(evt_o), 32'd0);
    step();
    chk("t4_issue_done_evt2", 32'(evt_o), 32'd0);
    aborts_before = abort_cnt;
    repeat (70000) step();
    chk("t4_no_abort", 32'(abort_cnt - aborts_before), 32'd0);
    chk("t4_no_timeout", 32'(timeout_o), 32'd0);
    chk("t4_still_busy", 32'(busy_o), 32'd1);
    finish_job(0);
    step();
    chk("t4_jobs_done", 32'(jobs_done_o), 32'd1);
    step();
    chk("sb_start_empty", 32'(exp_start.size()), 32'd0);
    chk("sb_evt_empty", 32'(exp_evt.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
